// File: rtl/turn_sequencer_pkg.sv
// Shared game encodings: action codes, positions, winner codes, FSM states.
// Also holds the end-of-turn winner decision used by the sequencer.
package game_pkg;

   typedef enum logic [2:0] {
      ACT_KICK   = 3'b000,
      ACT_PUNCH  = 3'b001,
      ACT_AWAIT  = 3'b010,
      ACT_JUMP   = 3'b011,
      ACT_LEFT1  = 3'b100,
      ACT_LEFT2  = 3'b101,
      ACT_RIGHT1 = 3'b110,
      ACT_RIGHT2 = 3'b111
   } action_e;

   typedef enum logic [3:0] {
      POS_FAR_LEFT  = 4'b0001,
      POS_LEFT      = 4'b0010,
      POS_RIGHT     = 4'b0100,
      POS_FAR_RIGHT = 4'b1000
   } pos_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_COMMIT = 3'd2,
      ST_SETTLE = 3'd3,
      ST_CHECK  = 3'd4,
      ST_OVER   = 3'd5
   } state_e;

   // WIN_NONE means the game goes on.
   function automatic winner_e decide_winner(
      input logic [1:0] h1,
      input logic [1:0] h2,
      input logic       last_turn
   );
      winner_e w;
      w = WIN_NONE;
      if (h1 == 2'd0 && h2 == 2'd0)
         w = WIN_DRAW;
      else if (h1 == 2'd0)
         w = WIN_P2;
      else if (h2 == 2'd0)
         w = WIN_P1;
      else if (last_turn) begin
         if (h1 > h2)
            w = WIN_P1;
         else if (h2 > h1)
            w = WIN_P2;
         else
            w = WIN_DRAW;
      end
      return w;
   endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Bundle between the input decoder / player modules and the sequencer.
// master drives requests and health; slave is the sequencer.
interface turn_sequencer_if #(
   parameter int TURN_W = 7
);
   logic              start;
   logic              ready1;
   logic              ready2;
   logic [2:0]        action_in1;
   logic [2:0]        action_in2;
   logic [1:0]        health1;
   logic [1:0]        health2;
   logic              actionEnable;
   logic [2:0]        action1;
   logic [2:0]        action2;
   logic              isGameOver;
   logic [1:0]        winner;
   logic [TURN_W-1:0] turn_count;

   modport master (
      output start, ready1, ready2,
      output action_in1, action_in2,
      output health1, health2,
      input  actionEnable, action1, action2,
      input  isGameOver, winner, turn_count
   );

   modport slave (
      input  start, ready1, ready2,
      input  action_in1, action_in2,
      input  health1, health2,
      output actionEnable, action1, action2,
      output isGameOver, winner, turn_count
   );
endinterface

// File: rtl/turn_sequencer_action_latch.sv
// Per-player action holder: first ready in a turn wins, silence at
// timeout becomes await, got flag cleared when a new turn opens.
module action_latch
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clear,
   input  logic       i_sample,
   input  logic       i_timeout,
   input  logic       i_ready,
   input  logic [2:0] i_action,
   output logic [2:0] o_action,
   output logic       o_got
);

   logic [2:0] r_action;
   logic       r_got;

   // Capture beats substitution when ready lands in the timeout cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_action <= ACT_AWAIT;
         r_got    <= 1'b0;
      end else if (i_clear) begin
         r_got <= 1'b0;
      end else if (i_sample && !r_got) begin
         if (i_ready) begin
            r_action <= i_action;
            r_got    <= 1'b1;
         end else if (i_timeout) begin
            r_action <= ACT_AWAIT;
         end
      end
   end

   assign o_action = r_action;
   assign o_got    = r_got;

endmodule

// File: rtl/turn_sequencer.sv
// Fight turn sequencer: gathers both actions, strobes one commit,
// then checks health and turn limit to end the game.
module turn_sequencer
   import game_pkg::*;
#(
   parameter int TURN_TIMEOUT = 16,
   parameter int TIMER_W      = 26,
   parameter int MAX_TURNS    = 99,
   parameter int TURN_W       = 7
) (
   input logic              clk,
   input logic              reset,
   turn_sequencer_if.slave  bus
);

   localparam logic [TIMER_W-1:0] LP_LAST =
      TIMER_W'(TURN_TIMEOUT - 1);
   localparam logic [TURN_W-1:0] LP_MAX =
      TURN_W'(MAX_TURNS);

   state_e              r_state;
   state_e              w_next;
   logic [TIMER_W-1:0]  r_timer;
   logic [TURN_W-1:0]   r_turn_count;
   logic [TURN_W-1:0]   w_turn_next;
   winner_e             r_winner;
   winner_e             w_win;
   logic                r_over;
   logic                w_clear;
   logic                w_sample;
   logic                w_timeout;
   logic                w_got1;
   logic                w_got2;
   logic [2:0]          w_act1;
   logic [2:0]          w_act2;

   assign w_turn_next = r_turn_count + TURN_W'(1);
   assign w_win = decide_winner(bus.health1, bus.health2,
                                w_turn_next == LP_MAX);

   action_latch u_latch1 (
      .clk       (clk),
      .rst_n     (reset),
      .i_clear   (w_clear),
      .i_sample  (w_sample),
      .i_timeout (w_timeout),
      .i_ready   (bus.ready1),
      .i_action  (bus.action_in1),
      .o_action  (w_act1),
      .o_got     (w_got1)
   );

   action_latch u_latch2 (
      .clk       (clk),
      .rst_n     (reset),
      .i_clear   (w_clear),
      .i_sample  (w_sample),
      .i_timeout (w_timeout),
      .i_ready   (bus.ready2),
      .i_action  (bus.action_in2),
      .o_action  (w_act2),
      .o_got     (w_got2)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state and turn-control strobes.
   always_comb begin
      w_next    = r_state;
      w_clear   = 1'b0;
      w_sample  = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next  = ST_WAIT;
               w_clear = 1'b1;
            end
         end
         ST_WAIT: begin
            w_sample  = 1'b1;
            w_timeout = (r_timer == LP_LAST);
            if ((w_got1 && w_got2) || w_timeout)
               w_next = ST_COMMIT;
         end
         ST_COMMIT: w_next = ST_SETTLE;
         ST_SETTLE: w_next = ST_CHECK;
         ST_CHECK: begin
            if (w_win != WIN_NONE) begin
               w_next = ST_OVER;
            end else begin
               w_next  = ST_WAIT;
               w_clear = 1'b1;
            end
         end
         ST_OVER: w_next = ST_OVER;
         default: w_next = ST_IDLE;
      endcase
   end

   // Turn timer: saturates at the last WAIT cycle, cleared per turn.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_timer <= '0;
      else if (w_clear)
         r_timer <= '0;
      else if (r_state == ST_WAIT && !w_timeout)
         r_timer <= r_timer + TIMER_W'(1);
   end

   // Turn count and game result, updated once per CHECK.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_turn_count <= '0;
         r_winner     <= WIN_NONE;
         r_over       <= 1'b0;
      end else if (r_state == ST_CHECK) begin
         r_turn_count <= w_turn_next;
         if (w_win != WIN_NONE) begin
            r_winner <= w_win;
            r_over   <= 1'b1;
         end
      end
   end

   assign bus.actionEnable = (r_state == ST_COMMIT);
   assign bus.action1      = w_act1;
   assign bus.action2      = w_act2;
   assign bus.isGameOver   = r_over;
   assign bus.winner       = r_winner;
   assign bus.turn_count   = r_turn_count;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: directed sequences, a turn
// table and randomized games against a turn-level reference model.
module tb_turn_sequencer;
   import game_pkg::*;

   localparam int TO = 16;
   localparam int MT = 3;
   localparam int TW = 7;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   turn_sequencer_if #(.TURN_W(TW)) bus ();

   turn_sequencer #(
      .TURN_TIMEOUT (TO),
      .TIMER_W      (26),
      .MAX_TURNS    (MT),
      .TURN_W       (TW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errs = 0;
   int checks = 0;

   typedef struct {
      logic [1:0] h1;
      logic [1:0] h2;
      logic [2:0] a1;
      logic [2:0] a2;
      logic       over;
      logic [1:0] win;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start = 1'b0;
      bus.ready1 = 1'b0;
      bus.ready2 = 1'b0;
      bus.action_in1 = 3'd0;
      bus.action_in2 = 3'd0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ae"}, 32'(bus.actionEnable), 0);
      chk({tag, "_a1"}, 32'(bus.action1), 32'(ACT_AWAIT));
      chk({tag, "_a2"}, 32'(bus.action2), 32'(ACT_AWAIT));
      chk({tag, "_over"}, 32'(bus.isGameOver), 0);
      chk({tag, "_win"}, 32'(bus.winner), 0);
      chk({tag, "_turns"}, 32'(bus.turn_count), 0);
   endtask

   task automatic enter_wait();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_pulse(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (bus.actionEnable) begin
            n = i;
            break;
         end
      end
   endtask

   // Turn-level rules: over flag in bit 2, winner code in bits 1:0.
   function automatic int model_result(int h1, int h2, int turns);
      bit d1;
      bit d2;
      d1 = (h1 == 0);
      d2 = (h2 == 0);
      if (d1 || d2)
         return 4 + (d2 ? 1 : 0) + (d1 ? 2 : 0);
      if (turns == MT)
         return 4 + (h1 >= h2 ? 1 : 0) + (h2 >= h1 ? 2 : 0);
      return 0;
   endfunction

   function automatic int pick_h();
      if ($urandom_range(0, 5) == 0)
         return 0;
      return int'($urandom_range(1, 3));
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int first;
      int cnt;

      tbl[0] = '{2'd3, 2'd0, 3'd0, 3'd3, 1'b1, 2'b01};
      tbl[1] = '{2'd0, 2'd3, 3'd5, 3'd6, 1'b1, 2'b10};
      tbl[2] = '{2'd0, 2'd0, 3'd7, 3'd1, 1'b1, 2'b11};
      tbl[3] = '{2'd1, 2'd2, 3'd4, 3'd0, 1'b0, 2'b00};
      tbl[4] = '{2'd2, 2'd1, 3'd3, 3'd7, 1'b0, 2'b00};

      bus.health1 = 2'd2;
      bus.health2 = 2'd3;
      idle_inputs();

      // Sequence A: three turns to the turn limit, then OVER.
      do_reset();
      chk_reset_vals("rst");
      enter_wait();
      bus.ready1 = 1'b1;
      bus.action_in1 = ACT_KICK;
      step();
      bus.ready1 = 1'b0;
      bus.ready2 = 1'b1;
      bus.action_in2 = ACT_PUNCH;
      step();
      bus.ready2 = 1'b0;
      chk("pair_early", 32'(bus.actionEnable), 0);
      step();
      chk("pair_pulse", 32'(bus.actionEnable), 1);
      chk("pair_a1", 32'(bus.action1), 32'(ACT_KICK));
      chk("pair_a2", 32'(bus.action2), 32'(ACT_PUNCH));
      step();
      chk("settle_low", 32'(bus.actionEnable), 0);
      step();
      step();
      chk("t1_turns", 32'(bus.turn_count), 1);
      chk("t1_over", 32'(bus.isGameOver), 0);

      bus.ready1 = 1'b1;
      bus.action_in1 = ACT_LEFT1;
      first = -1;
      for (int k = 1; k <= TO + 2; k++) begin
         step();
         if (k == 1) bus.ready1 = 1'b0;
         if (k == 5) begin
            bus.ready1 = 1'b1;
            bus.action_in1 = ACT_RIGHT1;
         end
         if (k == 6) bus.ready1 = 1'b0;
         if (bus.actionEnable) begin
            first = k;
            break;
         end
      end
      chk("to_commit_cycle", 32'(first), TO);
      chk("to_a1", 32'(bus.action1), 32'(ACT_LEFT1));
      chk("to_a2", 32'(bus.action2), 32'(ACT_AWAIT));
      step();
      step();
      step();
      chk("t2_turns", 32'(bus.turn_count), 2);
      chk("t2_over", 32'(bus.isGameOver), 0);

      bus.ready1 = 1'b1;
      bus.ready2 = 1'b1;
      bus.action_in1 = ACT_JUMP;
      bus.action_in2 = ACT_RIGHT2;
      step();
      idle_inputs();
      wait_pulse(20, n);
      chk("t3_latency", 32'(n), 1);
      chk("t3_a1", 32'(bus.action1), 32'(ACT_JUMP));
      chk("t3_a2", 32'(bus.action2), 32'(ACT_RIGHT2));
      step();
      step();
      step();
      chk("lim_over", 32'(bus.isGameOver), 1);
      chk("lim_win", 32'(bus.winner), 2);
      chk("lim_turns", 32'(bus.turn_count), 3);

      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         bus.start = 1'($urandom);
         bus.ready1 = 1'($urandom);
         bus.ready2 = 1'($urandom);
         bus.action_in1 = 3'($urandom_range(0, 7));
         bus.action_in2 = 3'($urandom_range(0, 7));
         step();
         if (bus.actionEnable) cnt++;
      end
      idle_inputs();
      chk("over_no_pulse", 32'(cnt), 0);
      chk("over_held", 32'(bus.isGameOver), 1);
      chk("over_win_held", 32'(bus.winner), 2);
      chk("over_turns_held", 32'(bus.turn_count), 3);

      // Sequence B: asynchronous reset in the middle of WAIT.
      bus.health1 = 2'd3;
      bus.health2 = 2'd3;
      do_reset();
      enter_wait();
      bus.ready1 = 1'b1;
      bus.action_in1 = ACT_JUMP;
      step();
      bus.ready1 = 1'b0;
      chk("mid_capture", 32'(bus.action1), 32'(ACT_JUMP));
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("async");
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.actionEnable) cnt++;
      end
      reset = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step();
         if (bus.actionEnable) cnt++;
      end
      chk("abort_no_pulse", 32'(cnt), 0);
      chk("abort_turns", 32'(bus.turn_count), 0);

      // Table of single-turn outcomes from a fresh game.
      for (int t = 0; t < 5; t++) begin
         do_reset();
         bus.health1 = tbl[t].h1;
         bus.health2 = tbl[t].h2;
         enter_wait();
         bus.ready1 = 1'b1;
         bus.ready2 = 1'b1;
         bus.action_in1 = tbl[t].a1;
         bus.action_in2 = tbl[t].a2;
         step();
         idle_inputs();
         wait_pulse(20, n);
         chk($sformatf("tbl%0d_lat", t), 32'(n), 1);
         chk($sformatf("tbl%0d_a1", t), 32'(bus.action1),
             32'(tbl[t].a1));
         chk($sformatf("tbl%0d_a2", t), 32'(bus.action2),
             32'(tbl[t].a2));
         step();
         step();
         step();
         chk($sformatf("tbl%0d_over", t), 32'(bus.isGameOver),
             32'(tbl[t].over));
         chk($sformatf("tbl%0d_win", t), 32'(bus.winner),
             32'(tbl[t].win));
         chk($sformatf("tbl%0d_turns", t), 32'(bus.turn_count), 1);
      end

      // Randomized games against the turn-level model.
      for (int g = 0; g < 40; g++) begin
         int turns;
         bit done;
         do_reset();
         enter_wait();
         turns = 0;
         done = 1'b0;
         while (!done) begin
            int h1, h2, d1, d2, a1, a2, off, res;
            bit c1, c2;
            h1 = pick_h();
            h2 = pick_h();
            bus.health1 = 2'(h1);
            bus.health2 = 2'(h2);
            d1 = int'($urandom_range(0, 22));
            d2 = int'($urandom_range(0, 22));
            a1 = int'($urandom_range(0, 7));
            a2 = int'($urandom_range(0, 7));
            c1 = (d1 < TO);
            c2 = (d2 < TO);
            off = TO;
            if (c1 && c2) begin
               off = (d1 > d2 ? d1 : d2) + 2;
               if (off > TO) off = TO;
            end
            first = -1;
            for (int k = 0; k <= TO; k++) begin
               bus.ready1 = (k == d1) ||
                  (k > d1 && $urandom_range(0, 3) == 0);
               bus.action_in1 = (k == d1) ? 3'(a1) :
                  3'($urandom_range(0, 7));
               bus.ready2 = (k == d2) ||
                  (k > d2 && $urandom_range(0, 3) == 0);
               bus.action_in2 = (k == d2) ? 3'(a2) :
                  3'($urandom_range(0, 7));
               step();
               if (bus.actionEnable && first < 0) first = k + 1;
               if (k + 1 == off) break;
            end
            idle_inputs();
            chk($sformatf("rnd%0d_commit", g), 32'(first), 32'(off));
            chk($sformatf("rnd%0d_a1", g), 32'(bus.action1),
                32'(c1 ? a1 : 2));
            chk($sformatf("rnd%0d_a2", g), 32'(bus.action2),
                32'(c2 ? a2 : 2));
            step();
            step();
            step();
            turns++;
            res = model_result(h1, h2, turns);
            chk($sformatf("rnd%0d_over", g), 32'(bus.isGameOver),
                32'(res >> 2));
            chk($sformatf("rnd%0d_win", g), 32'(bus.winner),
                32'(res & 3));
            chk($sformatf("rnd%0d_turns", g), 32'(bus.turn_count),
                32'(turns));
            if (res != 0 || turns >= MT) done = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-level controller that sequences fight turns for the two player modules.
- Each turn: collects one action per player (first `ready` pulse wins), substitutes `await` for any player silent at timeout, then issues a single `actionEnable` high/low cycle so each player commits exactly once.
- After each commit it checks health and turn count, and raises `isGameOver` with a winner code.
- Sits between the button/input decoder and both player modules; drives their `action1`, `action2`, `actionEnable` and `isGameOver` inputs.

Parameters:
- TURN_TIMEOUT, 16, clock cycles allowed in WAIT before forced commit (board build: 50_000_000).
- TIMER_W, 26, width of the turn timer; must hold TURN_TIMEOUT-1.
- MAX_TURNS, 99, turn limit; game ends after this many commits.
- TURN_W, 7, width of `turn_count`; must hold MAX_TURNS.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- start  input  1  level; leaves IDLE when high.
- ready1  input  1  player 1 action strobe; `action_in1` valid while high.
- ready2  input  1  player 2 action strobe; `action_in2` valid while high.
- action_in1  input  3  player 1 requested action code.
- action_in2  input  3  player 2 requested action code.
- health1  input  2  player 1 health from the player module.
- health2  input  2  player 2 health from the player module.
- actionEnable  output  1  commit strobe to both players.
- action1  output  3  registered committed action, player 1.
- action2  output  3  registered committed action, player 2.
- isGameOver  output  1  game finished.
- winner  output  2  00 none, 01 player1, 10 player2, 11 draw.
- turn_count  output  TURN_W  commits completed.

Behaviour:
- Reset values: state IDLE; `actionEnable`=0; `action1`=`action2`=await (3'b010); `isGameOver`=0; `winner`=00; `turn_count`=0; timer=0; both got flags=0.
- Reset is asynchronous; asserting it mid-turn aborts the turn with no commit strobe.
- States: IDLE, WAIT, COMMIT, SETTLE, CHECK, OVER.
- IDLE: stays while `start`=0. When `start`=1, go to WAIT; clear timer and got flags.
- WAIT: timer increments each cycle.
  - readyN=1 with gotN=0: capture `action_inN` into `actionN`, set gotN.
  - Later readyN pulses are ignored until the next turn.
  - Both got flags set → COMMIT on the next edge.
  - Timer == TURN_TIMEOUT-1 → COMMIT; any player with got=0 gets `actionN` = await.
  - A ready arriving in the timeout cycle is captured (capture beats substitution).
- COMMIT: `actionEnable`=1 for exactly one cycle; `action1`/`action2` are stable through this state and SETTLE.
- SETTLE: `actionEnable`=0 for one cycle; players re-arm and their updated health registers are valid.
- CHECK: increment `turn_count`, then evaluate:
  - h1==0 && h2==0 → draw.
  - h1==0 → winner=10.
  - h2==0 → winner=01.
  - `turn_count` (post-increment) == MAX_TURNS → higher health wins; equal health → 11.
  - Any of the above sets `isGameOver`=1 and goes to OVER; otherwise return to WAIT with timer and got flags cleared.
- OVER: `isGameOver`, `winner` and `turn_count` held; `actionEnable`=0. `start`, `ready` and `action_in` are all ignored; only reset leaves OVER.
- Inter-commit spacing: `actionEnable` is never high on two consecutive cycles; minimum 4 cycles between strobes.
- Health is compared only for ==0; wrapped values are the player module's concern.
- Timer never exceeds TURN_TIMEOUT-1 and does not wrap.

Decomposition:
- Package `game_pkg`:
  - action codes (kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111);
  - player position one-hot codes;
  - winner encodings;
  - FSM state enum.
- Sub-module `action_latch`, instantiated twice: holds the first-ready capture, got flag, await substitution and clear-on-new-turn logic.

Test Plan:
- Reset then start=1; ready1 with kick (000), next cycle ready2 with punch (001) → one `actionEnable` pulse 2 cycles after the second ready; action1=000, action2=001 during the pulse; turn_count=1.
- Only ready1 (left1) then silence, TURN_TIMEOUT=16 → commit 16 cycles after WAIT entry with action2=010; a second ready1 (right1) mid-turn is ignored.
- health2 forced to 00 before CHECK → isGameOver=1, winner=01; further start/ready produce no `actionEnable`.
- health1=health2=00 in the same CHECK → winner=11.
- MAX_TURNS=3, health1=2, health2=3 constant → game over after third commit with winner=10 and turn_count=3.
- Reset asserted during WAIT with got1 set → all outputs return to reset values immediately; no `actionEnable` pulse appears.
